i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
// - Parametrised I2C target with an on-chip register bank; successor to the single-port programming slave.
// - Samples SCL/SDA in the system clock domain. Open-drain SDA via an output-enable pin.
// - Supports pointer write, burst write, burst read and repeated START.
// - Sits behind the top-level SDA mux; exposes every register to the core as a flat bus.
// PARAMETERS
// - DEV_ADDR     7'h2A  7-bit target address matched after START
// - NUM_REGS     16     register count; power of 2, 2..256; PW = clog2(NUM_REGS)
// - SYNC_STAGES  2      flops in each SCL/SDA synchroniser, >=2
// - RESET_VAL    8'h00  reset value of every register
// PORTS
// - clk       in   1           system clock; must be >=8x the SCL rate
// - i2c_rst   in   1           asynchronous reset, active-high
// - scl_in    in   1           raw SCL
// - sda_in    in   1           raw SDA (pad input)
// - sda_oe    out  1           1 = pull SDA low; 0 = release
// - regs_flat out  NUM_REGS*8  reg[i] = regs_flat[8*i+7:8*i]
// - wr_stb    out  1           1-clk pulse when a register is written
// - wr_addr   out  PW          index written; valid with wr_stb
// - busy      out  1           high from an addressed START to STOP/NACK exit
// BEHAVIOUR
// - Reset values: sda_oe=0, wr_stb=0, wr_addr=0, busy=0, all regs=RESET_VAL, pointer=0, state=IDLE.
// - Reset is async: asserting it mid-transfer releases SDA in the same cycle.
// - Synchronisers: SCL/SDA pass through SYNC_STAGES flops; edges are detected on the synced values.
// - START: synced SDA falls while SCL=1. STOP: synced SDA rises while SCL=1.
// - START/STOP is honoured in any state. A START in any state goes to ADDR (repeated start).
// - A STOP goes to IDLE and clears busy. sda_oe is released on the same clk.
// - Bits are sampled on the SCL rising edge, MSB first. SDA is driven only after an SCL falling edge.
// - State transitions:
//   - IDLE: wait for START.
//   - ADDR: shift in 8 bits (7 address + R/W). On a match, go to ACK. On a mismatch, NACK (leave SDA released) and go to IGNORE.
//   - IGNORE: wait for START/STOP; sda_oe stays 0.
//   - ACK: drive sda_oe=1 from the falling edge after bit 8 until the falling edge after bit 9.
//     - After the address with W=0, go to PTR.
//     - After the address with R=1, go to RD and load the shifter with reg[pointer].
//   - PTR: take the first byte after a write address; pointer = byte[PW-1:0]. Upper bits are ignored. ACK, then go to WR.
//   - WR: each further byte goes to reg[pointer].
//     - wr_stb pulses 1 clk at the SCL falling edge that opens the ACK slot; wr_addr = pointer.
//     - The register updates the same clk. The pointer then increments. ACK, then stay in WR.
//   - RD: drive the MSB from the falling edge after the address ACK (sda_oe = ~bit). Shift on each later falling edge.
//     - At bit 9, release SDA and sample the controller's ACK on the rising edge.
//     - ACK (0): pointer++, reload the shifter, stay in RD.
//     - NACK (1): go to IGNORE.
// - Pointer wrap: the increment is modulo NUM_REGS; NUM_REGS-1 -> 0. There is no error and no NACK on wrap.
// - The pointer persists across transactions. A read without a preceding pointer write starts at the last pointer.
// - busy = 1 in ADDR (after a match), ACK, PTR, WR and RD.
// - Simultaneous events: a START/STOP in the same clk as a data edge wins. A partial byte is discarded and no write occurs.
// TESTING
// - Write 0x2A W, ptr 0x03, data 0xA5,0x5A, STOP -> reg3=A5, reg4=5A; two wr_stb pulses with wr_addr 3,4; 4 ACKs.
// - Wrong address 0x11 -> no ACK; sda_oe stays 0 through 0x11 W, 0x03, 0xFF; all regs unchanged; busy=0.
// - Write ptr 0x0F, data 0x01,0x02 (NUM_REGS=16) -> reg15=01, reg0=02 (wrap); ptr byte 0xF3 maps to reg3.
// - Write ptr 0x04, repeated START, 0x2A R, read 2 bytes (ACK, NACK) -> SDA returns 5A then reg5; IGNORE, busy=0 after NACK.
// - Assert i2c_rst mid-ACK -> sda_oe=0 the same cycle, regs=RESET_VAL, a following transaction works.
// - STOP injected after 4 data bits of a write -> no wr_stb, register unchanged, state IDLE.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target with an on-chip register bank. SCL/SDA are synchronised into the
// system clock domain. SDA is open-drain, driven via sda_oe. Supports pointer
// write, burst write, burst read and repeated START.
module i2c_slave_regfile #(
  parameter logic [6:0]  DEV_ADDR    = 7'h2A,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  localparam int unsigned PW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  i2c_rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [PW-1:0]         wr_addr,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ACK, S_PTR, S_WR, S_RD
  } state_t;

  state_t state, state_next, ret, ret_next;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start, stop;

  logic [7:0]    mem [NUM_REGS];
  logic [3:0]    bit_cnt, cnt_next;
  logic [7:0]    shreg, sh_next;
  logic [PW-1:0] ptr, ptr_next, ptr_inc;
  logic          oe_next, busy_next, we;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign ptr_inc  = ptr + 1'b1;

  // Synchronisers plus one delayed copy for edge detection; idle bus is high.
  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath decisions; START/STOP outrank any SCL edge.
  always_comb begin
    state_next = state;
    ret_next   = ret;
    oe_next    = sda_oe;
    busy_next  = busy;
    cnt_next   = bit_cnt;
    sh_next    = shreg;
    ptr_next   = ptr;
    we         = 1'b0;
    if (stop) begin
      state_next = S_IDLE;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
    end else if (start) begin
      state_next = S_ADDR;
      oe_next    = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            sh_next  = {shreg[6:0], sda_s};
            cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_next = '0;
            if (state == S_ADDR) begin
              if (shreg[7:1] == DEV_ADDR) begin
                busy_next  = 1'b1;
                oe_next    = 1'b1;
                state_next = S_ACK;
                ret_next   = shreg[0] ? S_RD : S_PTR;
              end else begin
                busy_next  = 1'b0;
                state_next = S_IGNORE;
              end
            end else if (state == S_PTR) begin
              ptr_next   = shreg[PW-1:0];
              oe_next    = 1'b1;
              state_next = S_ACK;
              ret_next   = S_WR;
            end else begin
              we         = 1'b1;
              ptr_next   = ptr_inc;
              oe_next    = 1'b1;
              state_next = S_ACK;
              ret_next   = S_WR;
            end
          end
        end
        S_ACK: begin
          // Falls alternate with rises, so the next fall here closes the ACK slot.
          if (scl_fall) begin
            oe_next    = 1'b0;
            cnt_next   = '0;
            state_next = ret;
            if (ret == S_RD) begin
              sh_next = mem[ptr];
              oe_next = ~mem[ptr][7];
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            if (bit_cnt == 4'd8) begin
              if (sda_s) begin
                state_next = S_IGNORE;
                busy_next  = 1'b0;
              end else begin
                cnt_next = 4'd9;
              end
            end else begin
              cnt_next = bit_cnt + 4'd1;
            end
          end else if (scl_fall) begin
            if (bit_cnt == 4'd9) begin
              ptr_next = ptr_inc;
              sh_next  = mem[ptr_inc];
              oe_next  = ~mem[ptr_inc][7];
              cnt_next = '0;
            end else if (bit_cnt == 4'd8) begin
              oe_next = 1'b0;
            end else begin
              sh_next = {shreg[6:0], 1'b0};
              oe_next = ~shreg[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol datapath registers and the write strobe.
  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      ret     <= S_PTR;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      sda_oe  <= oe_next;
      busy    <= busy_next;
      bit_cnt <= cnt_next;
      shreg   <= sh_next;
      ptr     <= ptr_next;
      ret     <= ret_next;
      wr_stb  <= we;
      if (we) wr_addr <= ptr;
    end
  end

  // Register bank.
  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[ptr] <= shreg;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = mem[g];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Randomised bench for i2c_slave_regfile: a bit-banged I2C controller plus a
// transaction-level model of the register bank, pointer and busy flag.
module tb_i2c_slave_regfile;

  localparam logic [6:0] DEV = 7'h2A;
  localparam int         Q   = 5;   // clk cycles per quarter SCL period

  logic         clk = 1'b0;
  logic         i2c_rst = 1'b1;
  logic         scl = 1'b1;
  logic         m_sda = 1'b1;
  logic         sda_bus;
  logic         sda_oe;
  logic [127:0] regs_flat;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic         busy;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_regfile #(
    .DEV_ADDR(DEV), .NUM_REGS(16), .SYNC_STAGES(2), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .i2c_rst(i2c_rst), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .regs_flat(regs_flat), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  mreg [16];
  logic [3:0]  mptr;
  logic        mbusy;
  logic [11:0] exp_q [$];
  logic [7:0]  pay [8];
  logic [7:0]  rd_got [8];
  logic        bus_idle = 1'b1;

  // Per-bit expectations used by the compare process
  logic chk_en = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_busy = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare process: bus-level outputs during each SCL-high window, and every
  // write strobe against the next expected write.
  always @(negedge clk) begin
    if (!i2c_rst) begin
      if (chk_en) begin
        check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
      end
      if (wr_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_stb", {28'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
          check("wr_data", {24'd0, regs_flat[8*wr_addr +: 8]}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input logic e_oe, input logic e_busy, output logic seen);
    scl = 1'b0;  wait_clk(Q);
    m_sda = b;   wait_clk(Q);
    scl = 1'b1;  wait_clk(Q);
    exp_oe = e_oe; exp_busy = e_busy; chk_en = 1'b1;
    wait_clk(Q);
    seen = sda_bus;
    chk_en = 1'b0;
  endtask

  task automatic i2c_start();
    if (!bus_idle) begin
      scl = 1'b0;   wait_clk(Q);
      m_sda = 1'b1; wait_clk(Q);
      scl = 1'b1;   wait_clk(Q);
    end
    m_sda = 1'b0; wait_clk(Q);
    bus_idle = 1'b0;
  endtask

  task automatic i2c_stop();
    scl = 1'b0;   wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_sda = 1'b1; wait_clk(2*Q);
    bus_idle = 1'b1;
    mbusy = 1'b0;
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("oe_after_stop", {31'd0, sda_oe}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e_ack, input logic busy_bits, input logic busy_ack);
    logic s;
    for (int i = 7; i >= 0; i--) drive_bit(b[i], 1'b0, busy_bits, s);
    drive_bit(1'b1, e_ack, busy_ack, s);
  endtask

  task automatic recv_byte(input logic [7:0] e, input logic mack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(1'b1, ~e[i], 1'b1, s);
      got[i] = s;
    end
    drive_bit(~mack, 1'b0, mack, s);
  endtask

  task automatic compare_regs();
    check("wr_pending", exp_q.size(), 32'd0);
    for (int i = 0; i < 16; i++)
      check("reg", {24'd0, regs_flat[8*i +: 8]}, {24'd0, mreg[i]});
  endtask

  // Write transaction: pay[0] is the pointer byte, pay[1..n-1] are data.
  task automatic wr_txn(input logic [6:0] a, input int unsigned n, input logic do_stop);
    logic m;
    m = (a == DEV);
    i2c_start();
    send_byte({a, 1'b0}, m, mbusy, m);
    mbusy = m;
    for (int unsigned k = 0; k < n; k++) begin
      if (m) begin
        if (k == 0) begin
          mptr = pay[0][3:0];
        end else begin
          exp_q.push_back({mptr, pay[k]});
          mreg[mptr] = pay[k];
          mptr = mptr + 4'd1;
        end
      end
      send_byte(pay[k], m, mbusy, mbusy);
    end
    if (do_stop) i2c_stop();
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START.
  task automatic rd_txn(input logic with_ptr, input logic [7:0] pv, input int unsigned n);
    logic [7:0] got, e;
    logic mack;
    if (with_ptr) begin
      pay[0] = pv;
      wr_txn(DEV, 1, 1'b0);
    end
    i2c_start();
    send_byte({DEV, 1'b1}, 1'b1, mbusy, 1'b1);
    mbusy = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      mack = (k != n - 1);
      e = mreg[mptr];
      recv_byte(e, mack, got);
      rd_got[k] = got;
      check("rd_byte", {24'd0, got}, {24'd0, e});
      if (mack) mptr = mptr + 4'd1;
      else      mbusy = 1'b0;
    end
    i2c_stop();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mptr = 4'd0;
    mbusy = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    model_reset();
    wait_clk(4);
    i2c_rst = 1'b0;
    wait_clk(4);

    // Reset state
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_regs", (regs_flat == '0) ? 32'd1 : 32'd0, 32'd1);

    // Pointer write plus burst write
    pay[0] = 8'h03; pay[1] = 8'hA5; pay[2] = 8'h5A;
    wr_txn(DEV, 3, 1'b1);
    check("lit_reg3", {24'd0, regs_flat[8*3 +: 8]}, 32'hA5);
    check("lit_reg4", {24'd0, regs_flat[8*4 +: 8]}, 32'h5A);
    compare_regs();

    // Wrong address: no ACK, nothing written
    pay[0] = 8'h03; pay[1] = 8'hFF;
    wr_txn(7'h11, 2, 1'b1);
    compare_regs();

    // Pointer wrap and upper pointer bits ignored
    pay[0] = 8'h0F; pay[1] = 8'h01; pay[2] = 8'h02;
    wr_txn(DEV, 3, 1'b1);
    check("lit_reg15", {24'd0, regs_flat[8*15 +: 8]}, 32'h01);
    check("lit_reg0", {24'd0, regs_flat[8*0 +: 8]}, 32'h02);
    pay[0] = 8'hF3; pay[1] = 8'hC3;
    wr_txn(DEV, 2, 1'b1);
    check("lit_reg3_f3", {24'd0, regs_flat[8*3 +: 8]}, 32'hC3);
    compare_regs();

    // Pointer write, repeated START, read with ACK then NACK
    rd_txn(1'b1, 8'h04, 2);
    check("lit_rd0", {24'd0, rd_got[0]}, 32'h5A);
    check("lit_rd1", {24'd0, rd_got[1]}, 32'h00);
    compare_regs();

    // Reset while the target drives an ACK
    i2c_start();
    send_byte({DEV, 1'b0}, 1'b1, mbusy, 1'b1);
    mbusy = 1'b1;
    send_byte(8'h07, 1'b1, 1'b1, 1'b1);
    check("oe_before_rst", {31'd0, sda_oe}, 32'd1);
    i2c_rst = 1'b1;
    #1;
    check("oe_async_rst", {31'd0, sda_oe}, 32'd0);
    check("busy_async_rst", {31'd0, busy}, 32'd0);
    wait_clk(3);
    check("regs_after_rst", (regs_flat == '0) ? 32'd1 : 32'd0, 32'd1);
    model_reset();
    scl = 1'b1; m_sda = 1'b1; bus_idle = 1'b1;
    i2c_rst = 1'b0;
    wait_clk(5);
    pay[0] = 8'h02; pay[1] = 8'h77;
    wr_txn(DEV, 2, 1'b1);
    rd_txn(1'b1, 8'h02, 1);
    check("lit_rd_after_rst", {24'd0, rd_got[0]}, 32'h77);
    compare_regs();

    // STOP injected after four data bits: partial byte is dropped
    pay[0] = 8'h09;
    wr_txn(DEV, 1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b1, s);
    i2c_stop();
    compare_regs();

    // Randomised transactions
    for (int it = 0; it < 30; it++) begin
      int unsigned kind, n;
      logic [6:0] a;
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        n = $urandom_range(1, 5);
        for (int unsigned k = 0; k < n; k++) pay[k] = 8'($urandom);
        wr_txn(DEV, n, 1'b1);
      end else if (kind == 5) begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = 7'h11;
        n = $urandom_range(1, 3);
        for (int unsigned k = 0; k < n; k++) pay[k] = 8'($urandom);
        wr_txn(a, n, 1'b1);
      end else if (kind <= 8) begin
        n = $urandom_range(1, 4);
        rd_txn(1'($urandom_range(0, 1)), 8'($urandom), n);
      end else begin
        pay[0] = 8'($urandom);
        wr_txn(DEV, 1, 1'b0);
        n = $urandom_range(1, 7);
        for (int unsigned k = 0; k < n; k++) drive_bit(1'($urandom), 1'b0, 1'b1, s);
        i2c_stop();
      end
      compare_regs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
